// File: rtl/bsg_axil_fifo_pkt_arbiter.sv
// Round-robin packet arbiter: grants one requester at a time to the host-bound FIFO slot for a
// whole fixed-length packet, gated by downstream credits. BSG_FIFO_PKT_ARB_STATS_EN adds counters.
module bsg_axil_fifo_pkt_arbiter #(
  parameter int unsigned num_req_p   = 4,
  parameter int unsigned width_p     = 32,
  parameter int unsigned pkt_words_p = 4,
  parameter int unsigned credits_p   = 16,
  localparam int unsigned IdW        = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int unsigned CredW      = $clog2(credits_p + 1),
  localparam int unsigned CntW       = $clog2(pkt_words_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_req_p-1:0]         req_v_i,
  input  logic [num_req_p*width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]         req_yumi_o,
  output logic                         fifo_v_o,
  output logic [width_p-1:0]           fifo_data_o,
  input  logic                         fifo_ready_i,
  input  logic                         credit_return_i,
  output logic                         busy_o,
  output logic [IdW-1:0]               grant_id_o,
  output logic [CredW-1:0]             credits_o,
  output logic [num_req_p*32-1:0]      pkt_count_o
);

  localparam int unsigned SumW = CredW + 1;

  if (num_req_p < 2) begin : g_bad_num_req
    $fatal(1, "bsg_axil_fifo_pkt_arbiter: num_req_p must be >= 2");
  end
  if (credits_p < pkt_words_p) begin : g_bad_credits
    $fatal(1, "bsg_axil_fifo_pkt_arbiter: credits_p must be >= pkt_words_p");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [CredW-1:0] credits_q, credits_d;
  logic [CntW-1:0]  word_q, word_d;

  logic             found, elig, hs, last_hs;
  logic [IdW-1:0]   sel, idx;
  logic [SumW-1:0]  cred_sum;

  // Search starts just after the last grant and wraps, giving round-robin fairness.
  always_comb begin
    found = 1'b0;
    sel   = grant_q;
    idx   = grant_q;
    for (int unsigned i = 1; i <= num_req_p; i++) begin
      idx = IdW'((32'(grant_q) + i) % num_req_p);
      if (!found && req_v_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign elig        = (state_q == StIdle) && (credits_q >= CredW'(pkt_words_p)) && found;
  assign fifo_v_o    = (state_q == StSend) && req_v_i[grant_q];
  assign fifo_data_o = req_data_i[32'(grant_q)*width_p +: width_p];
  assign hs          = fifo_v_o && fifo_ready_i;
  assign last_hs     = hs && (word_q == CntW'(pkt_words_p - 1));
  assign busy_o      = (state_q == StSend);
  assign grant_id_o  = grant_q;
  assign credits_o   = credits_q;

  always_comb begin
    req_yumi_o          = '0;
    req_yumi_o[grant_q] = hs;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (elig) begin
          state_d = StSend;
          grant_d = sel;
          word_d  = '0;
        end
      end
      StSend: begin
        if (hs) begin
          word_d = word_q + CntW'(1);
          if (last_hs) begin
            state_d = StIdle;
            word_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant debit and return credit apply together; an overfull pool clamps at credits_p.
  always_comb begin
    cred_sum  = {1'b0, credits_q} + SumW'(credit_return_i)
              - (elig ? SumW'(pkt_words_p) : SumW'(0));
    credits_d = (cred_sum > SumW'(credits_p)) ? CredW'(credits_p) : cred_sum[CredW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      grant_q   <= IdW'(num_req_p - 1);
      credits_q <= CredW'(credits_p);
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      credits_q <= credits_d;
      word_q    <= word_d;
    end
  end

`ifdef BSG_FIFO_PKT_ARB_STATS_EN
  for (genvar i = 0; i < num_req_p; i++) begin : g_stats
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (last_hs && (32'(grant_q) == i)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) cnt_q <= '0;
      else            cnt_q <= cnt_d;
    end

    assign pkt_count_o[i*32 +: 32] = cnt_q;
  end
`else
  assign pkt_count_o = '0;
`endif

  // A return into a full pool means downstream returned more than it was given.
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                   !(credit_return_i && !elig && (credits_q == CredW'(credits_p))))
    else $error("bsg_axil_fifo_pkt_arbiter: credit return while pool full");

endmodule

// File: tb/tb_bsg_axil_fifo_pkt_arbiter.sv
// Self-checking bench for bsg_axil_fifo_pkt_arbiter (4 requesters, 4-word packets, 16 credits).
`timescale 1ns/1ps
module tb_bsg_axil_fifo_pkt_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned PW = 4;
  localparam int unsigned CP = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_v;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     yumi;
  logic              fifo_v;
  logic [W-1:0]      fifo_data;
  logic              ready;
  logic              ret;
  logic              busy;
  logic [1:0]        gid;
  logic [4:0]        credits;
  logic [NR*32-1:0]  pkt_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned seq [NR];

  always #5 clk = ~clk;

  bsg_axil_fifo_pkt_arbiter #(
    .num_req_p  (NR),
    .width_p    (W),
    .pkt_words_p(PW),
    .credits_p  (CP)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .req_v_i        (req_v),
    .req_data_i     (req_data),
    .req_yumi_o     (yumi),
    .fifo_v_o       (fifo_v),
    .fifo_data_o    (fifo_data),
    .fifo_ready_i   (ready),
    .credit_return_i(ret),
    .busy_o         (busy),
    .grant_id_o     (gid),
    .credits_o      (credits),
    .pkt_count_o    (pkt_count)
  );

  // Each requester presents {id, its own word sequence number}.
  task automatic set_data();
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = {8'(i), seq[i][23:0]};
  endtask

  // Called after the negedge checks: consume accepted words, cross the edge, drive point.
  task automatic next_cycle();
    for (int i = 0; i < NR; i++) if (yumi[i]) seq[i]++;
    @(posedge clk);
    #1;
    set_data();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_v   = '0;
    ready   = 1'b0;
    ret     = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();
    for (int i = 0; i < NR; i++) seq[i] = 0;
    set_data();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] obs, exp;
    do_reset();
    @(negedge clk);
    obs = {busy, gid, credits, fifo_v, yumi};
    exp = {1'b0, 2'd3, 5'd16, 1'b0, 4'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, exp);
    end
    n_checks++;
    if (pkt_count !== '0) begin
      n_fail++;
      $display("FAIL reset_pkt_count: got %h want 0", pkt_count);
    end
    next_cycle();
  endtask

  // All requesters busy: five-cycle rhythm of one idle cycle plus four data words.
  task automatic test_round_robin();
    logic [12:0] obs, exp;
    int p, ph;
    do_reset();
    req_v = '1;
    ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      p  = c / 5;
      ph = c % 5;
      @(negedge clk);
      if (p < 4 && ph > 0) exp = {1'b1, 2'(p), 5'(16 - 4*(p+1)), 1'b1, 4'(1 << p)};
      else                 exp = {1'b0, (p == 0) ? 2'd3 : 2'(p-1), 5'(16 - 4*p), 1'b0, 4'b0};
      obs = {busy, gid, credits, fifo_v, yumi};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got %h want %h", c, obs, exp);
      end
      if (p < 4 && ph > 0) begin
        n_checks++;
        if (fifo_data !== {8'(p), 24'(ph-1)}) begin
          n_fail++;
          $display("FAIL rr_data%0d: got %h want %h", c, fifo_data, {8'(p), 24'(ph-1)});
        end
      end
      next_cycle();
    end
  endtask

  // Continues from the drained pool left by test_round_robin.
  task automatic test_credit_starvation();
    logic [12:0] obs, exp;
    for (int k = 0; k < 4; k++) begin
      ret = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, credits} !== {1'b0, 5'(k)}) begin
        n_fail++;
        $display("FAIL starve_pulse%0d: got busy=%b cred=%0d want busy=0 cred=%0d",
                 k, busy, credits, k);
      end
      next_cycle();
    end
    ret = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, credits} !== {1'b0, 5'd4}) begin
      n_fail++;
      $display("FAIL starve_refilled: got busy=%b cred=%0d want busy=0 cred=4", busy, credits);
    end
    next_cycle();
    @(negedge clk);
    obs = {busy, gid, credits, fifo_v, yumi};
    exp = {1'b1, 2'd0, 5'd0, 1'b1, 4'b0001};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL starve_grant: got %h want %h", obs, exp);
    end
    next_cycle();
  endtask

  task automatic test_ready_toggle();
    int  cnt;
    bit  m_busy, done, exp_y;
    do_reset();
    req_v  = 4'b0100;
    cnt    = 0;
    m_busy = 1'b0;
    done   = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      ready = (c % 2) == 0;
      @(negedge clk);
      exp_y = m_busy && ready;
      n_checks++;
      if ((yumi & 4'b1011) !== 4'b0) begin
        n_fail++;
        $display("FAIL toggle_other_yumi c%0d: got %b want 0000 on others", c, yumi);
      end
      n_checks++;
      if ({fifo_v, yumi[2]} !== {m_busy, exp_y}) begin
        n_fail++;
        $display("FAIL toggle_word c%0d: got v=%b yumi=%b want v=%b yumi=%b",
                 c, fifo_v, yumi[2], m_busy, exp_y);
      end
      if (!m_busy) m_busy = 1'b1;
      else if (exp_y) begin
        cnt++;
        if (cnt == PW) begin
          m_busy = 1'b0;
          done   = 1'b1;
        end
      end
      next_cycle();
      if (done) req_v = '0;
    end
    @(negedge clk);
    n_checks++;
    if (cnt != PW || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_end: got words=%0d busy=%b want words=4 busy=0", cnt, busy);
    end
    next_cycle();
  endtask

  task automatic test_grant_and_return();
    logic [12:0] obs, exp;
    int n;
    do_reset();
    req_v = 4'b0001;
    ready = 1'b1;
    n     = 0;
    for (int c = 0; c < 40 && n < 12; c++) begin
      @(negedge clk);
      if (yumi[0]) n++;
      next_cycle();
      if (n == 12) req_v = '0;
    end
    @(negedge clk);
    n_checks++;
    if (n != 12 || {busy, credits} !== {1'b0, 5'd4}) begin
      n_fail++;
      $display("FAIL gr_setup: got words=%0d busy=%b cred=%0d want 12/0/4", n, busy, credits);
    end
    next_cycle();
    ret = 1'b1;
    @(negedge clk);
    next_cycle();
    req_v = 4'b0001;
    @(negedge clk);
    n_checks++;
    if ({busy, credits} !== {1'b0, 5'd5}) begin
      n_fail++;
      $display("FAIL gr_at5: got busy=%b cred=%0d want busy=0 cred=5", busy, credits);
    end
    next_cycle();
    ret = 1'b0;
    @(negedge clk);
    obs = {busy, gid, credits, fifo_v, yumi};
    exp = {1'b1, 2'd0, 5'd2, 1'b1, 4'b0001};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL gr_both_applied: got %h want %h", obs, exp);
    end
    next_cycle();
  endtask

  task automatic test_mid_packet_reset();
    logic [12:0] obs, exp;
    int n;
    do_reset();
    req_v = 4'b0010;
    ready = 1'b1;
    n     = 0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      @(negedge clk);
      if (yumi[1]) n++;
      next_cycle();
    end
    reset_n = 1'b0;
    ready   = 1'b0;
    req_v   = 4'b1111;
    @(negedge clk);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    obs = {busy, gid, credits, fifo_v, yumi};
    exp = {1'b0, 2'd3, 5'd16, 1'b0, 4'b0};
    n_checks++;
    if (n != 2 || obs !== exp) begin
      n_fail++;
      $display("FAIL midreset_state: got words=%0d %h want 2 %h", n, obs, exp);
    end
    next_cycle();
    @(negedge clk);
    obs = {busy, gid, credits, fifo_v, yumi};
    exp = {1'b1, 2'd0, 5'd12, 1'b1, 4'b0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL midreset_regrant: got %h want %h", obs, exp);
    end
    next_cycle();
  endtask

  task automatic test_stats();
    int n;
    do_reset();
`ifdef BSG_FIFO_PKT_ARB_STATS_EN
    force dut.g_stats[1].cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    next_cycle();
    release dut.g_stats[1].cnt_q;
    @(negedge clk);
    n_checks++;
    if (pkt_count[63:32] !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL stats_preload: got %h want ffffffff", pkt_count[63:32]);
    end
    next_cycle();
`endif
    req_v = 4'b0010;
    ready = 1'b1;
    n     = 0;
    for (int c = 0; c < 20 && n < PW; c++) begin
      @(negedge clk);
      if (yumi[1]) n++;
      next_cycle();
      if (n == PW) req_v = '0;
    end
    @(negedge clk);
    n_checks++;
    if (n != PW || pkt_count !== '0) begin
      n_fail++;
      $display("FAIL stats_after_pkt: got words=%0d counts=%h want 4 and all 0", n, pkt_count);
    end
    next_cycle();
  endtask

  // Random valids, ready and returns against a transaction-level model of the arbiter rules.
  task automatic test_random();
    logic [12:0] obs, exp;
    bit          m_busy, exp_v, picked;
    int          m_grant, m_credits, m_words, idx;
    int unsigned m_cnt [NR];
    logic [3:0]  exp_yumi;
    do_reset();
    m_busy    = 1'b0;
    m_grant   = NR - 1;
    m_credits = CP;
    m_words   = 0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    for (int c = 0; c < 500; c++) begin
      req_v = 4'($urandom);
      ready = $urandom_range(0, 3) != 0;
      ret   = (m_credits < CP) && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      exp_v    = m_busy && req_v[m_grant];
      exp_yumi = (exp_v && ready) ? 4'(1 << m_grant) : 4'b0;
      exp      = {m_busy, 2'(m_grant), 5'(m_credits), exp_v, exp_yumi};
      obs      = {busy, gid, credits, fifo_v, yumi};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rand_c%0d: got %h want %h", c, obs, exp);
      end
      if (exp_v) begin
        n_checks++;
        if (fifo_data !== {8'(m_grant), seq[m_grant][23:0]}) begin
          n_fail++;
          $display("FAIL rand_data_c%0d: got %h want %h", c, fifo_data,
                   {8'(m_grant), seq[m_grant][23:0]});
        end
      end
      if (!m_busy) begin
        if (m_credits >= PW && req_v != 0) begin
          picked = 1'b0;
          for (int k = 1; k <= NR; k++) begin
            idx = (m_grant + k) % NR;
            if (!picked && req_v[idx]) begin
              picked  = 1'b1;
              m_grant = idx;
            end
          end
          m_busy    = 1'b1;
          m_credits = m_credits - PW;
          m_words   = 0;
        end
      end else if (exp_v && ready) begin
        m_words++;
        if (m_words == PW) begin
          m_busy = 1'b0;
          m_cnt[m_grant]++;
        end
      end
      if (ret) m_credits = (m_credits + 1 > CP) ? CP : m_credits + 1;
      next_cycle();
    end
    req_v = '0;
    ret   = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
`ifdef BSG_FIFO_PKT_ARB_STATS_EN
      n_checks++;
      if (pkt_count[i*32 +: 32] !== m_cnt[i]) begin
        n_fail++;
        $display("FAIL rand_count%0d: got %0d want %0d", i, pkt_count[i*32 +: 32], m_cnt[i]);
      end
`else
      n_checks++;
      if (pkt_count[i*32 +: 32] !== 32'd0) begin
        n_fail++;
        $display("FAIL rand_count%0d: got %0d want 0 (%0d packets done)", i,
                 pkt_count[i*32 +: 32], m_cnt[i]);
      end
`endif
    end
    next_cycle();
  endtask

  initial begin
    reset_n  = 1'b0;
    req_v    = '0;
    ready    = 1'b0;
    ret      = 1'b0;
    req_data = '0;
    for (int i = 0; i < NR; i++) seq[i] = 0;
    test_reset();
    test_round_robin();
    test_credit_starvation();
    test_ready_toggle();
    test_grant_and_return();
    test_mid_packet_reset();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bsg_axil_fifo_pkt_arbiter.md
Name: bsg_axil_fifo_pkt_arbiter

Overview:
- Shares one host-bound transmit FIFO slot among several on-chip packet requesters.
- Grants in round-robin order. Each grant is held for exactly one fixed-length packet, so packets are never interleaved.
- A grant is issued only when the downstream receive credit pool can absorb the whole packet.
- Sits upstream of the AXI-Lite FIFO adapter's fifo_data_i/fifo_v_i slot. Credits are returned by the host-read dequeue.

Parameters:
- num_req_p, 4, number of requesters (>=2).
- width_p, 32, data word width.
- pkt_words_p, 4, words per packet; matches the host receive-length granularity.
- credits_p, 16, downstream receive FIFO depth in words (>= pkt_words_p).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous active-low reset.
- req_v_i  in  num_req_p  per-requester word valid.
- req_data_i  in  num_req_p x width_p  per-requester word.
- req_yumi_o  out  num_req_p  word consumed from requester.
- fifo_v_o  out  1  word valid to FIFO slot.
- fifo_data_o  out  width_p  word to FIFO slot.
- fifo_ready_i  in  1  FIFO slot can accept.
- credit_return_i  in  1  one word dequeued downstream (one credit per pulse).
- busy_o  out  1  packet in flight (SEND state).
- grant_id_o  out  clog2(num_req_p)  current or last granted requester.
- credits_o  out  clog2(credits_p+1)  available credits.
- pkt_count_o  out  num_req_p x 32  completed packets per requester (optional feature).

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-low, on reset_n_i. Every register updates only on the rising edge of clk_i; reset takes effect at the edge where reset_n_i=0.
- Reset values:
  - state=IDLE; busy_o=0; fifo_v_o=0; req_yumi_o=0.
  - grant_id_o=num_req_p-1, so the first search starts at requester 0.
  - credits_o=credits_p; word counter=0; pkt_count_o all 0.
- States: IDLE, SEND.
- IDLE:
  - Eligible when credits_o >= pkt_words_p and any req_v_i is set.
  - If eligible, select the first set req_v_i scanning upward from grant_id_o+1, wrapping modulo num_req_p.
  - Register the selection into grant_id_o, subtract pkt_words_p from credits, clear the word counter, go to SEND.
  - fifo_v_o=0 in IDLE.
  - A requester's valid in IDLE is only sampled; nothing is consumed.
- SEND:
  - fifo_v_o = req_v_i[grant_id_o]; fifo_data_o = req_data_i[grant_id_o].
  - req_yumi_o[grant_id_o] = fifo_v_o & fifo_ready_i; all other yumi bits are 0.
  - Each handshake increments the word counter.
  - The handshake on word pkt_words_p-1 returns to IDLE, clears the word counter and increments pkt_count_o[grant_id_o].
  - Requester bubbles (req_v low) stall without a timeout; the grant is held.
- Latency:
  - Grant is one cycle after eligibility. First word can transfer in the cycle after that.
  - Back-to-back packets have exactly one IDLE bubble cycle between them.
- Credits:
  - next = credits - (grant ? pkt_words_p : 0) + credit_return_i.
  - A grant and a return in the same cycle are both applied.
  - A return while at credits_p saturates at credits_p and fires a simulation-only assertion error.
  - The eligibility check uses the registered credit value, not same-cycle returns.
- fifo_data_o is don't-care when fifo_v_o=0; drive it as the granted requester's data anyway (no masking).
- Reset mid-packet: the partial packet is abandoned (remaining words are not sent), credits are restored to credits_p, and the arbitration pointer resets. Requester and FIFO are reset by the same signal.
- num_req_p<2 or credits_p<pkt_words_p: simulation $fatal at time 0.

Optional Feature:
- BSG_FIFO_PKT_ARB_STATS_EN defined: pkt_count_o holds per-requester 32-bit packet-completion counters. They increment at each final-word handshake, wrap from 0xFFFF_FFFF to 0, and reset to 0.
- Undefined: pkt_count_o is tied to 0 and the counters are not instantiated. All other behaviour is identical.

Test Plan:
- Reset, then req_v_i=4'b1111, fifo_ready_i=1, no credit returns, pkt_words_p=4, credits_p=16:
  - Packets are granted to 0,1,2,3 in order, each 4 consecutive words.
  - Gap of one cycle between packets.
  - credits_o steps 16->12->8->4->0, then busy_o stays 0.
- Credit starvation: credits_o=0 with requests pending, then 3 credit_return_i pulses → no grant. The 4th pulse → grant the next cycle and credits_o=0 again.
- Requester 2 only, fifo_ready_i toggling 1010…:
  - Words transfer only on ready cycles.
  - Exactly 4 req_yumi_o[2] pulses; no yumi to other requesters.
  - Return to IDLE after the 4th.
- Grant plus simultaneous credit_return_i in the same cycle at credits_o=5 → credits_o=2 next cycle.
- Reset asserted after word 2 of a packet → outputs at reset values next cycle, credits_o=16, next grant goes to requester 0.
- STATS_EN defined, pkt_count_o[1] preloaded by force to 0xFFFF_FFFF, one packet from requester 1 → pkt_count_o[1]=0. With the macro undefined, pkt_count_o always reads 0.
